// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Ports: clk/reset, req/we/addr/wdata per side in, gnt/rvalid per side and rdata out, rf_* drive the register file.
module regfile_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic [DW-1:0] rdata,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [AW-1:0] rf_read_addr,
  output logic [AW-1:0] rf_write_addr,
  output logic [DW-1:0] rf_write_data,
  output logic          rf_regwrite,
  input  logic [DW-1:0] rf_read_data
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          rvalid_a_q, rvalid_a_d;
  logic          rvalid_b_q, rvalid_b_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win_b;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    regwrite_d = 1'b0;
    win_b      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          // B wins alone, or when both ask and prio points at B
          win_b      = req_b && (!req_a || prio_q);
          state_d    = ACCESS;
          gnt_a_d    = !win_b;
          gnt_b_d    = win_b;
          prio_d     = !win_b;
          addr_d     = win_b ? addr_b : addr_a;
          wdata_d    = win_b ? wdata_b : wdata_a;
          regwrite_d = win_b ? we_b : we_a;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        // regwrite_q carries the latched we during ACCESS
        if (!regwrite_q) begin
          rdata_d    = rf_read_data;
          rvalid_a_d = gnt_a_q;
          rvalid_b_d = gnt_b_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      regwrite_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      regwrite_q <= regwrite_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign gnt_a         = gnt_a_q;
  assign gnt_b         = gnt_b_q;
  assign rvalid_a      = rvalid_a_q;
  assign rvalid_b      = rvalid_b_q;
  assign rdata         = rdata_q;
  assign rf_read_addr  = addr_q;
  assign rf_write_addr = addr_q;
  assign rf_write_data = wdata_q;
  assign rf_regwrite   = regwrite_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a transaction-level reference model.
// Drives two requesters, models the register file, checks grants, rf_* and read returns.
module tb_regfile_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk, reset;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, rf_regwrite;
  logic [DW-1:0] rdata, rf_write_data, rf_read_data;
  logic [AW-1:0] rf_read_addr, rf_write_addr;

  typedef struct {
    bit       we;
    bit [2:0] addr;
    bit [7:0] data;
  } op_t;

  typedef struct {
    int       cyc;
    bit       side;
    bit       we;
    bit [2:0] addr;
    bit [7:0] data;
    bit [7:0] old;
  } exp_t;

  typedef struct {
    int       cyc;
    bit       side;
    bit [7:0] data;
  } rexp_t;

  op_t   qa[$], qb[$];
  exp_t  eq[$];
  rexp_t rq[$];

  logic [7:0] rf [8] = '{8'h00, 8'h11, 8'h22, 8'h33,
                         8'h44, 8'h55, 8'h66, 8'h77};
  bit   [7:0] mem [8];
  bit   [7:0] last_rd;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit busy, prio, as_a, as_b, pend_a, pend_b, have_arb;
  exp_t last_arb;

  regfile_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b),
    .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rdata(rdata),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rf_read_addr(rf_read_addr),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .rf_regwrite(rf_regwrite),
    .rf_read_data(rf_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    if (rf_regwrite) rf[rf_write_addr] <= rf_write_data;
  assign rf_read_data = rf[rf_read_addr];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic mon_check();
    exp_t  e;
    rexp_t r;
    while (eq.size() > 0 && eq[0].cyc < cyc) begin
      e = eq.pop_front();
      chk("gnt_missing_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (eq.size() > 0 && eq[0].cyc == cyc) begin
      e = eq.pop_front();
      chk("gnt_a", gnt_a, !e.side);
      chk("gnt_b", gnt_b, e.side);
      chk("rf_regwrite", rf_regwrite, e.we);
      chk("rf_write_addr", rf_write_addr, e.addr);
      chk("rf_read_addr", rf_read_addr, e.addr);
      chk("rf_write_data", rf_write_data, e.data);
    end else begin
      chk("idle_gnt_we", {gnt_a, gnt_b, rf_regwrite}, 0);
    end
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      r = rq.pop_front();
      chk("rvalid_missing_cycle", 32'(cyc), 32'(r.cyc));
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      chk("rvalid_a", rvalid_a, !r.side);
      chk("rvalid_b", rvalid_b, r.side);
      chk("rdata", rdata, r.data);
      last_rd = r.data;
    end else begin
      chk("idle_rvalid", {rvalid_a, rvalid_b}, 0);
      chk("rdata_hold", rdata, last_rd);
    end
  endtask

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (reset) last_rd = '0;
    else mon_check();
  end

  function automatic op_t rand_op();
    op_t o;
    o.we   = 1'($urandom % 2);
    o.addr = 3'($urandom % 8);
    o.data = 8'($urandom);
    return o;
  endfunction

  task automatic drive();
    req_a = as_a;
    req_b = as_b;
    if (as_a) begin
      we_a = qa[0].we; addr_a = qa[0].addr; wdata_a = qa[0].data;
    end else begin
      we_a = 1'($urandom); addr_a = 3'($urandom); wdata_a = 8'($urandom);
    end
    if (as_b) begin
      we_b = qb[0].we; addr_b = qb[0].addr; wdata_b = qb[0].data;
    end else begin
      we_b = 1'($urandom); addr_b = 3'($urandom); wdata_b = 8'($urandom);
    end
  endtask

  // One cycle: requesters react to grants, then the model predicts the next edge.
  task automatic step(int pa, int pb);
    bit   wb;
    op_t  o;
    exp_t e;
    rexp_t r;
    @(negedge clk);
    if (pend_a) begin void'(qa.pop_front()); as_a = 0; pend_a = 0; end
    if (pend_b) begin void'(qb.pop_front()); as_b = 0; pend_b = 0; end
    if (gnt_a) pend_a = 1;
    if (gnt_b) pend_b = 1;
    if (!as_a && qa.size() > 0 && int'($urandom_range(99)) < pa) as_a = 1;
    if (!as_b && qb.size() > 0 && int'($urandom_range(99)) < pb) as_b = 1;
    drive();
    if (!busy && (as_a || as_b)) begin
      wb     = (as_a && as_b) ? prio : as_b;
      o      = wb ? qb[0] : qa[0];
      prio   = !wb;
      e.cyc  = cyc + 1;
      e.side = wb;
      e.we   = o.we;
      e.addr = o.addr;
      e.data = o.data;
      e.old  = mem[o.addr];
      eq.push_back(e);
      if (o.we) begin
        mem[o.addr] = o.data;
      end else begin
        r.cyc = cyc + 2; r.side = wb; r.data = mem[o.addr];
        rq.push_back(r);
      end
      last_arb = e;
      have_arb = 1;
      busy = 1;
    end else begin
      busy = 0;
    end
  endtask

  task automatic drain(int pa, int pb);
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 300) begin
      step(pa, pb);
      n++;
    end
    if (qa.size() > 0 || qb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending_a=%0d pending_b=%0d required=0",
               qa.size(), qb.size());
    end
  endtask

  task automatic abort();
    reset = 1;
    #1;
    chk("abort_regwrite", rf_regwrite, 0);
    chk("abort_gnt_a", gnt_a, 0);
    chk("abort_waddr", rf_write_addr, 0);
    if (have_arb && last_arb.we) mem[last_arb.addr] = last_arb.old;
    eq.delete(); rq.delete(); qa.delete(); qb.delete();
    as_a = 0; as_b = 0; pend_a = 0; pend_b = 0;
    busy = 0; prio = 0;
    drive();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i * 17);
    busy = 0; prio = 0; as_a = 0; as_b = 0;
    pend_a = 0; pend_b = 0; have_arb = 0;
    reset = 1;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    #1;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    chk("rst_regwrite", rf_regwrite, 0);
    chk("rst_raddr", rf_read_addr, 0);
    chk("rst_waddr", rf_write_addr, 0);
    chk("rst_wdata", rf_write_data, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    // write 3/A5 then read 3, write 7/FF then read 7 from the other side
    qa.push_back('{1'b1, 3'd3, 8'hA5});
    qa.push_back('{1'b1, 3'd7, 8'hFF});
    qb.push_back('{1'b0, 3'd3, 8'h00});
    qb.push_back('{1'b0, 3'd7, 8'h00});
    drain(100, 100);

    // both held continuously: alternation
    for (int i = 0; i < 6; i++) begin
      qa.push_back(rand_op());
      qb.push_back(rand_op());
    end
    drain(100, 100);

    // B alone for four grants, then A joins and must win next
    for (int i = 0; i < 4; i++) qb.push_back(rand_op());
    drain(0, 100);
    qa.push_back(rand_op());
    qb.push_back(rand_op());
    drain(100, 100);

    // reset during the write access of 5/3C, then read 5 back
    qa.push_back('{1'b1, 3'd5, 8'h3C});
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(100, 0);
      got = pend_a;
    end
    chk("abort_gnt_seen", got, 1);
    abort();
    qb.push_back('{1'b0, 3'd5, 8'h00});
    drain(0, 100);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (qa.size() < 2) qa.push_back(rand_op());
      if (qb.size() < 2) qb.push_back(rand_op());
      step(40, 40);
    end
    drain(100, 100);
    repeat (4) step(0, 0);
    chk("eq_empty", eq.size(), 0);
    chk("rq_empty", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
